// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_prefetch
//  Description : Instruction-fetch unit with a prefetch queue, placed between
//                pc generation and instruction decode. Fetches sequentially
//                from RESET_PC over a valid/ready request channel, buffers the
//                in-order rom responses in a DEPTH-entry FIFO and presents
//                {pc, inst} to decode over valid/ready. A redirect flushes the
//                queue and discards any responses still in flight.
//  Ports       :
//    clk, rst          clock (rising edge), asynchronous active-high reset
//    mem_req_*         fetch request channel toward rom (valid/ready/addr)
//    mem_rsp_*         in-order response channel from rom (valid/data)
//    redirect_*        1-cycle branch/jump redirect pulse and target pc
//    inst_*            FIFO head toward decode (valid/ready/data/pc)
//    fifo_level_o      current FIFO occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_data_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [CNT_W-1:0]  fifo_level_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  level;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];

    logic              req_valid;
    logic              req_fire;
    logic              rsp_accept;
    logic              rsp_drop;
    logic              redir;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    credit_sum;
    logic [CNT_W-1:0]  outstanding_nxt;
    logic [CNT_W-1:0]  drop_cnt_nxt;
    logic [ADDR_W-1:0] redirect_base;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits: FIFO entries plus requests in flight never exceed DEPTH, so
    // every response has a guaranteed slot and the FIFO cannot overflow.
    assign credit_sum = {1'b0, level} + {1'b0, outstanding};
    assign req_valid  = (state != S_BOOT) && (credit_sum < DEPTH_C);
    assign req_fire   = req_valid && mem_req_ready_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_accept = mem_rsp_valid_i && (outstanding != '0);
    assign rsp_drop   = rsp_accept && (drop_cnt != '0);
    assign redir      = redirect_valid_i && (state != S_BOOT);
    // A good response arriving in the redirect cycle belongs to the old
    // stream and is discarded together with the FIFO contents.
    assign push       = rsp_accept && (drop_cnt == '0) && !redir;
    assign pop        = (level != '0) && inst_ready_i;

    assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_accept);
    // Everything still in flight after the redirect cycle is stale.
    assign drop_cnt_nxt    = redir ? outstanding_nxt : (drop_cnt - CNT_W'(rsp_drop));
    assign redirect_base   = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            level       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;

            case (state)
                S_BOOT:  state <= S_RUN;
                S_RUN:   state <= (redir && (outstanding_nxt != '0)) ? S_FLUSH : S_RUN;
                S_FLUSH: state <= (drop_cnt_nxt == '0) ? S_RUN : S_FLUSH;
                default: state <= S_BOOT;
            endcase

            if (redir) begin
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                level    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                level <= level + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: reads are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_data[wr_ptr] <= mem_rsp_data_i;
        end
    end

    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = fetch_pc;
    assign inst_valid_o    = (level != '0);
    assign inst_data_o     = inst_valid_o ? fifo_data[rd_ptr] : '0;
    assign inst_pc_o       = inst_valid_o ? fifo_pc[rd_ptr]   : '0;
    assign fifo_level_o    = level;

endmodule
`default_nettype wire
